// File: rtl/spi_fifo_port.sv
`default_nettype none
// =============================================================================
// Module      : spi_fifo_port
// Description : Buffered SPIGate port with a data window at ADDRESS and a
//               status/flag register at ADDRESS+1. The host fills an RX FIFO
//               that the fabric drains. The fabric fills a TX FIFO that the
//               host drains. Overflow and underrun are kept as sticky flags.
//               Optional feature macro: SPI_FIFO_PORT_IRQ_EN (IRQ output).
// Revision    : 1.0 - initial release
// =============================================================================
module spi_fifo_port #(
    parameter logic [7:0]    ADDRESS       = 8'h00,
    parameter int            DW            = 16,
    parameter int            DEPTH_LOG2    = 4,
    parameter logic [DW-1:0] UNDERRUN_WORD = 16'hDEAD
`ifdef SPI_FIFO_PORT_IRQ_EN
    ,
    parameter int            IRQ_LEVEL     = 8
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] RXD,
    input  logic [7:0]    ADDR,
    input  logic          RXE,
    input  logic          TXE,
    output logic [DW-1:0] TXD,
    input  logic [DW-1:0] WR_DATA,
    input  logic          WR_EN,
    output logic          WR_FULL,
    output logic [DW-1:0] RD_DATA,
    input  logic          RD_EN,
    output logic          RD_EMPTY
`ifdef SPI_FIFO_PORT_IRQ_EN
    ,
    output logic          IRQ
`endif
);

    localparam int            DEPTH          = 1 << DEPTH_LOG2;
    localparam int            CW             = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CNT_FULL       = CW'(DEPTH);
    localparam logic [7:0]    STATUS_ADDRESS = ADDRESS + 8'd1;

    generate
        if (DW < 2 * (DEPTH_LOG2 + 1) + 2) begin : g_dw_check
            $error("spi_fifo_port: DW too narrow for the status word");
        end
    endgenerate

    logic [DW-1:0]         rx_mem_q [DEPTH];
    logic [DW-1:0]         tx_mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d;
    logic [DEPTH_LOG2-1:0] rx_rptr_q, rx_rptr_d;
    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d;
    logic [DEPTH_LOG2-1:0] tx_rptr_q, tx_rptr_d;
    logic [CW-1:0]         rx_cnt_q,  rx_cnt_d;
    logic [CW-1:0]         tx_cnt_q,  tx_cnt_d;
    logic                  rx_ovf_q,  rx_ovf_d;
    logic                  tx_udr_q,  tx_udr_d;

    logic                  host_data_wr;
    logic                  host_stat_wr;
    logic                  host_data_rd;
    logic                  rx_empty, rx_full;
    logic                  tx_empty, tx_full;
    logic                  rx_push,  rx_pop;
    logic                  tx_push,  tx_pop;
    logic [1:0]            flag_clr;
    logic [CW-1:0]         rx_free;
    logic [DW-1:0]         status;

    always_comb begin
        host_data_wr = RXE && (ADDR == ADDRESS);
        host_stat_wr = RXE && (ADDR == STATUS_ADDRESS);
        host_data_rd = TXE && (ADDR == ADDRESS);

        rx_empty     = (rx_cnt_q == '0);
        rx_full      = (rx_cnt_q == CNT_FULL);
        tx_empty     = (tx_cnt_q == '0);
        tx_full      = (tx_cnt_q == CNT_FULL);

        // A pop in the same cycle frees a slot, so a push into a full FIFO
        // is still accepted when the other side drains concurrently.
        rx_pop       = RD_EN && !rx_empty;
        rx_push      = host_data_wr && (!rx_full || rx_pop);
        tx_pop       = host_data_rd && !tx_empty;
        tx_push      = WR_EN && (!tx_full || tx_pop);

        flag_clr     = host_stat_wr ? RXD[1:0] : 2'b00;
        rx_ovf_d     = (rx_ovf_q && !flag_clr[0]) || (host_data_wr && !rx_push);
        tx_udr_d     = (tx_udr_q && !flag_clr[1]) || (host_data_rd && tx_empty);

        rx_wptr_d    = rx_wptr_q + DEPTH_LOG2'(rx_push);
        rx_rptr_d    = rx_rptr_q + DEPTH_LOG2'(rx_pop);
        tx_wptr_d    = tx_wptr_q + DEPTH_LOG2'(tx_push);
        tx_rptr_d    = tx_rptr_q + DEPTH_LOG2'(tx_pop);
        rx_cnt_d     = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        tx_cnt_d     = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            rx_ovf_q  <= 1'b0;
            tx_udr_q  <= 1'b0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_udr_q  <= tx_udr_d;
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge CLK) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= RXD;
        end
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= WR_DATA;
        end
    end

`ifdef SPI_FIFO_PORT_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (int'(tx_cnt_q) < IRQ_LEVEL) || rx_ovf_q || tx_udr_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign IRQ = irq_q;
`endif

    always_comb begin
        rx_free           = CNT_FULL - rx_cnt_q;
        status            = '0;
        status[0]         = rx_ovf_q;
        status[1]         = tx_udr_q;
        status[2 +: CW]   = tx_cnt_q;
        status[2 + CW +: CW] = rx_free;
`ifdef SPI_FIFO_PORT_IRQ_EN
        status[DW-1]      = irq_q;
`endif
    end

    // TXD is OR-combined with other SPIGate ports, so drive zero when idle.
    always_comb begin
        TXD = '0;
        if (ADDR == ADDRESS) begin
            TXD = tx_empty ? UNDERRUN_WORD : tx_mem_q[tx_rptr_q];
        end else if (ADDR == STATUS_ADDRESS) begin
            TXD = status;
        end
    end

    assign RD_DATA  = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
    assign RD_EMPTY = rx_empty;
    assign WR_FULL  = tx_full;

endmodule
`default_nettype wire
